// File: rtl/seq_div_32_pkg.sv
// Shared width, FSM encoding and operand helpers for the sequential 32-bit divider.
package seq_div_32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Magnitude of x when treated as two's complement; 0x80000000 stays 0x80000000 as unsigned.
  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] x, input logic sgn);
    return (sgn && x[DATA_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/seq_div_32_div_step.sv
// One restoring division step: 33-bit trial subtract (inverted divisor, carry-in 1) plus restore mux.
module seq_div_32_div_step
  import seq_div_32_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  bit_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  always_comb begin
    shifted  = {rem, bit_in};
    trial    = shifted + ~{1'b0, divisor} + {{DATA_WIDTH{1'b0}}, 1'b1};
    q_bit    = ~trial[DATA_WIDTH];
    // trial[32] set means the subtract borrowed: keep the shifted partial remainder
    rem_next = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle signed/unsigned 32-bit restoring divider, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// RUN   | 32 shift-subtract iterations (one cycle only when divisor is zero)
// FIN   | done pulse, result registers valid
module seq_div_32
  import seq_div_32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   quo, rem, dvs;
  logic [DATA_WIDTH-1:0]   quo_step, rem_step;
  logic [CNT_W-1:0]        cnt;
  logic                    sign_q, sign_r, dz;
  logic                    q_bit;
  logic                    accept, last_iter;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (cnt == {CNT_W{1'b1}});
  assign quo_step  = {quo[DATA_WIDTH-2:0], q_bit};

  seq_div_32_div_step u_step (
    .rem      (rem),
    .bit_in   (quo[DATA_WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (dz || last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz       <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == FIN);
      if (accept) begin
        dvs      <= mag(b, is_signed);
        // On divide-by-zero quo carries the raw dividend through to R
        quo      <= (b == '0) ? a : mag(a, is_signed);
        rem      <= '0;
        cnt      <= '0;
        sign_q   <= is_signed & (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]);
        sign_r   <= is_signed & a[DATA_WIDTH-1];
        dz       <= (b == '0);
        div_zero <= 1'b0;
      end else if (state == RUN) begin
        if (dz) begin
          q        <= '1;
          r        <= quo;
          div_zero <= 1'b1;
        end else begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_iter) begin
            q <= sign_q ? -quo_step : quo_step;
            r <= sign_r ? -rem_step : rem_step;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: driver pushes hand-computed results, monitor checks on done.
module tb_seq_div_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q, r;
  logic        busy, done, div_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  seq_div_32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .q(q), .r(r), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check32("q", q, e.q);
        check32("r", r, e.r);
        check32("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
        check32("latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                       input logic push, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz);
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; is_signed = s; start = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz;
      e.lat = edz ? 1 : 32;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    check32("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz);
    issue(ia, ib, s, 1'b1, eq, er, edz);
    wait_done();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check32("rst_q", q, 32'h0);
    check32("rst_r", r, 32'h0);
    check32("rst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'd100,        32'd7,          1'b0, 32'd14,       32'd2,        1'b0);
    run(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,        1'b0);
    run(32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC, 32'd1,        1'b0);
    run(32'd5,          32'd0,          1'b0, 32'hFFFFFFFF, 32'd5,        1'b1);
    run(32'hFFFFFFF9,   32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    run(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,        1'b0);
    run(32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000, 1'b0);
    run(32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,        1'b0);

    // start and operand changes during RUN must be ignored
    issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1; a = 32'd55; b = 32'd0; is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // reset mid-RUN clears everything and leaves no result behind
    issue(32'd1000, 32'd3, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check32("midrst_q", q, 32'h0);
    check32("midrst_r", r, 32'h0);
    check32("midrst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check32("post_rst_idle", {29'd0, busy, done, div_zero}, 32'h0);

    run(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
